// File: rtl/rca_seq_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
// Build option: RCA_SEQ_OVF_EN adds the signed-overflow flag.
package rca_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} rca_seq_state_t;

  localparam int SLICE_W = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rca_seq_ctrl_if.sv
// Request/response bundle of rca_seq_ctrl (valid/ready on both sides).
// Build option: RCA_SEQ_OVF_EN adds out_ovf.
interface rca_seq_ctrl_if
  import rca_seq_pkg::*;
#(
  parameter int N_SLICES = 4
);
  localparam int W = SLICE_W * N_SLICES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;
`ifdef RCA_SEQ_OVF_EN
  logic         out_ovf;
`endif

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub,
    output out_ready,
    input  in_ready, out_valid, out_sum,
    input  out_cout, busy
`ifdef RCA_SEQ_OVF_EN
    , input out_ovf
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub,
    input  out_ready,
    output in_ready, out_valid, out_sum,
    output out_cout, busy
`ifdef RCA_SEQ_OVF_EN
    , output out_ovf
`endif
  );

endinterface

// File: rtl/rca_seq_ctrl_nibble_add.sv
// Combinational 4-bit ripple-carry adder; also exposes the carry into
// bit 3 so the caller can derive signed overflow.
module nibble_add (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_s,
  output logic       o_cout,
  output logic       o_c3
);

  logic [4:0] w_c;

  always_comb begin
    w_c    = '0;
    o_s    = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < 4; i++) begin
      o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1] = (i_a[i] & i_b[i]) |
                 (i_a[i] & w_c[i]) |
                 (i_b[i] & w_c[i]);
    end
  end

  assign o_cout = w_c[4];
  assign o_c3   = w_c[3];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Wide add/subtract built from one nibble adder, LS nibble first.
// Build option: RCA_SEQ_OVF_EN adds a signed-overflow output.
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int N_SLICES = 4
) (
  input  logic         clk,
  input  logic         rst,
  rca_seq_ctrl_if.slave bus
);

  localparam int W    = SLICE_W * N_SLICES;
  localparam int IDXW = idx_w(N_SLICES);
  localparam logic [IDXW-1:0] LAST = IDXW'(N_SLICES - 1);

  rca_seq_state_t r_state;
  rca_seq_state_t w_next;

  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;

  logic [SLICE_W-1:0] w_s;
  logic               w_cout;
  logic               w_c3;
  logic               w_accept;
  logic               w_run;
  logic               w_last;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN:  if (r_idx == LAST) w_next = DONE;
      DONE: if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_run  = (r_state == RUN);
  assign w_last = w_run && (r_idx == LAST);

  // Operands shift right so the slice always sees the low nibble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.in_a;
      r_b     <= bus.in_sub ? ~bus.in_b : bus.in_b;
      r_carry <= bus.in_sub ? 1'b1 : bus.in_cin;
      r_idx   <= '0;
    end else if (w_run) begin
      r_a     <= r_a >> SLICE_W;
      r_b     <= r_b >> SLICE_W;
      r_carry <= w_cout;
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
      r_sum[{r_idx, 2'b00} +: SLICE_W] <= w_s;
    end
  end

  nibble_add u_nib (
    .i_a    (r_a[SLICE_W-1:0]),
    .i_b    (r_b[SLICE_W-1:0]),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout),
    .o_c3   (w_c3)
  );

`ifdef RCA_SEQ_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst)         r_ovf <= 1'b0;
    else if (w_last) r_ovf <= w_c3 ^ w_cout;
  end

  assign bus.out_ovf = r_ovf;
`else
  logic w_unused_c3;
  assign w_unused_c3 = w_c3;
`endif

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.out_sum   = r_sum;
  assign bus.out_cout  = r_carry;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl: directed vectors, corner sequences and
// random operations against an arithmetic reference model.
module tb_rca_seq_ctrl;
  import rca_seq_pkg::*;

  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rca_seq_ctrl_if #(.N_SLICES(N)) bus ();

  rca_seq_ctrl #(.N_SLICES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub,
                       output logic [W-1:0] s, output logic co,
                       output logic ov);
    int sa;
    int sb;
    int r;
    logic [W:0] t;
    sa = $signed(a);
    sb = $signed(b);
    if (!sub) begin
      t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      s  = t[W-1:0];
      co = t[W];
      r  = sa + sb + int'(cin);
    end else begin
      s  = a - b;
      co = (a >= b);
      r  = sa - sb;
    end
    ov = (r > 32767) || (r < -32768);
  endtask

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    bit acc;
    acc = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_sub   = sub;
    for (int k = 0; k < 30; k++) begin
      if (bus.in_ready) begin
        @(posedge clk);
        acc = 1;
        break;
      end
      @(negedge clk);
    end
    if (!acc) check("accept_timeout", 0, 1);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input bit scramble, output int lat);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
      if (scramble) begin
        bus.in_a   = W'($urandom);
        bus.in_b   = W'($urandom);
        bus.in_cin = 1'($urandom);
        bus.in_sub = 1'($urandom);
      end
    end
    if (lat < 0) check("valid_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub,
                        output logic [W-1:0] s, output logic co,
                        output logic ov, output int lat);
    start(a, b, cin, sub);
    wait_valid(1'b1, lat);
    s  = bus.out_sum;
    co = bus.out_cout;
`ifdef RCA_SEQ_OVF_EN
    ov = bus.out_ovf;
`else
    ov = 1'b0;
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] s;
    logic [W-1:0] es;
    logic         co;
    logic         eco;
    logic         ov;
    logic         eov;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    logic [W-1:0] held;
    int           lat;
    int           seen;

    vt[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    vt[5] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vt[6] = '{16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0};
    vt[7] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
    vt[8] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_sum", 32'(bus.out_sum), 0);
    check("rst_out_cout", 32'(bus.out_cout), 0);
    check("rst_busy", 32'(bus.busy), 0);
`ifdef RCA_SEQ_OVF_EN
    check("rst_out_ovf", 32'(bus.out_ovf), 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, s, co, ov, lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), N);
      check($sformatf("vec%0d_sum", i), 32'(s), 32'(vt[i].s));
      check($sformatf("vec%0d_cout", i), 32'(co), 32'(vt[i].co));
`ifdef RCA_SEQ_OVF_EN
      check($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vt[i].ov));
`endif
      check($sformatf("vec%0d_idle", i), 32'(bus.in_ready), 1);
    end

    // Back-pressure with a new request waiting.
    @(negedge clk);
    bus.out_ready = 1'b0;
    start(16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_valid(1'b0, lat);
    held = bus.out_sum;
    check("bp_sum", 32'(held), 32'h2345);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h0001;
    bus.in_b     = 16'h0001;
    bus.in_cin   = 1'b0;
    bus.in_sub   = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("bp_hold_sum", 32'(bus.out_sum), 32'(held));
      check("bp_hold_in_ready", 32'(bus.in_ready), 0);
      check("bp_hold_valid", 32'(bus.out_valid), 1);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(bus.out_valid), 0);
    check("bp_release_ready", 32'(bus.in_ready), 1);
    check("bp_release_sum", 32'(bus.out_sum), 32'(held));
    @(posedge clk);
    #1;
    check("bp_next_busy", 32'(bus.busy), 1);
    check("bp_next_ready", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    wait_valid(1'b1, lat);
    check("bp_next_lat", 32'(lat), N);
    check("bp_next_sum", 32'(bus.out_sum), 32'h0002);
    @(posedge clk);
    #1;

    // Reset during the second RUN cycle.
    start(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_state_ready", 32'(bus.in_ready), 1);
    check("abort_valid", 32'(bus.out_valid), 0);
    check("abort_sum", 32'(bus.out_sum), 0);
    check("abort_busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("abort_no_output", 32'(seen), 0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, s, co, ov, lat);
    check("abort_after_sum", 32'(s), 32'h0002);
    check("abort_after_cout", 32'(co), 0);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      model(ra, rb, rc, rs, es, eco, eov);
      run_op(ra, rb, rc, rs, s, co, ov, lat);
      check($sformatf("rnd%0d_sum", i), 32'(s), 32'(es));
      check($sformatf("rnd%0d_cout", i), 32'(co), 32'(eco));
      check($sformatf("rnd%0d_lat", i), 32'(lat), N);
`ifdef RCA_SEQ_OVF_EN
      check($sformatf("rnd%0d_ovf", i), 32'(ov), 32'(eov));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
